// File: rtl/color_bounce_pkg.sv
// Shared constants and types for the colour-bounce game core.
// Holds the platform start layout, the scroller FSM state type and LFSR constants.
package color_bounce_pkg;

    localparam int         Y_MAX_DEFAULT = 116;

    // Start layout: platforms evenly spaced down the playfield
    localparam logic [6:0] PLAT_Y0 = 7'd0;
    localparam logic [6:0] PLAT_Y1 = 7'd29;
    localparam logic [6:0] PLAT_Y2 = 7'd58;
    localparam logic [6:0] PLAT_Y3 = 7'd87;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3)
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } scroll_state_t;

    // Packed start layout, platform k at [7k+6:7k]
    function automatic logic [27:0] start_layout();
        return {PLAT_Y3, PLAT_Y2, PLAT_Y1, PLAT_Y0};
    endfunction

endpackage

// File: rtl/plat_scroller_if.sv
// Controller/drawer-facing bus of the platform scroller.
// master = controller side (drives strobes), slave = plat_scroller.
interface plat_scroller_if;
    logic        step;
    logic        restart;
    logic        gameover;
    logic [31:0] curr_score;
    logic [27:0] position_plats;
    logic [27:0] prev_plats;
    logic        plats_valid;
    logic        busy;
    logic [3:0]  spawn;

    modport master (
        output step, restart, gameover, curr_score,
        input  position_plats, prev_plats, plats_valid, busy, spawn
    );

    modport slave (
        input  step, restart, gameover, curr_score,
        output position_plats, prev_plats, plats_valid, busy, spawn
    );
endinterface

// File: rtl/plat_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used for random platform respawn heights.
// Only instantiated when PLAT_RANDOM_SPAWN_EN is defined.
module plat_lfsr
    import color_bounce_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    output logic [7:0] lfsr
);

    // Shift left every clock, feedback is the XOR of the tapped bits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= LFSR_SEED;
        else         lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end

endmodule

// File: rtl/plat_scroller.sv
// Platform scroller: owns the four platform y positions, slides them down by a
// score-dependent speed on each step (one platform per cycle) and respawns any
// platform reaching the floor. Optional macro PLAT_RANDOM_SPAWN_EN selects an
// LFSR-derived respawn height instead of row 0.
module plat_scroller
    import color_bounce_pkg::*;
#(
    parameter int Y_MAX       = Y_MAX_DEFAULT,
    parameter int SPEED_SHIFT = 3,
    parameter int MAX_SPEED   = 4
) (
    input  logic            clk,
    input  logic            resetn,
    plat_scroller_if.slave  bus
);

    scroll_state_t   state;
    logic [1:0]      idx;
    logic [7:0]      speed;
    logic [7:0]      speed_nxt;
    logic [31:0]     score_lvl;
    logic [3:0]      spawn_acc;
    logic [3:0][6:0] plats;
    logic [3:0][6:0] prev;
    logic [7:0]      sum;
    logic [6:0]      respawn_y;
    logic            valid_q;
    logic            busy_q;
    logic [3:0]      spawn_q;

`ifdef PLAT_RANDOM_SPAWN_EN
    logic [7:0] lfsr;

    plat_lfsr u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .lfsr   (lfsr)
    );

    assign respawn_y = {3'b000, lfsr[3:0]};
`else
    assign respawn_y = 7'd0;
`endif

    // Speed = 1 + min(score >> SPEED_SHIFT, MAX_SPEED-1); the cap test is done
    // at full 32-bit width so huge scores never wrap into a slow speed
    always_comb begin
        score_lvl = bus.curr_score >> SPEED_SHIFT;
        if (score_lvl >= 32'(MAX_SPEED - 1)) speed_nxt = 8'(MAX_SPEED);
        else                                 speed_nxt = score_lvl[7:0] + 8'd1;
    end

    // 8-bit sum of the platform being swept, so the floor test never wraps
    always_comb begin
        sum = {1'b0, plats[idx]} + speed;
    end

    // Scroll FSM; restart overrides every state and suppresses the valid pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            idx       <= 2'd0;
            speed     <= 8'd1;
            spawn_acc <= 4'd0;
            plats     <= start_layout();
            prev      <= start_layout();
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            spawn_q   <= 4'd0;
        end else if (bus.restart) begin
            state     <= IDLE;
            idx       <= 2'd0;
            spawn_acc <= 4'd0;
            plats     <= start_layout();
            prev      <= start_layout();
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            spawn_q   <= 4'd0;
        end else begin
            valid_q <= 1'b0;
            spawn_q <= 4'd0;
            case (state)
                IDLE: begin
                    if (bus.step && !bus.gameover) begin
                        prev      <= plats;
                        speed     <= speed_nxt;
                        idx       <= 2'd0;
                        spawn_acc <= 4'd0;
                        busy_q    <= 1'b1;
                        state     <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (sum >= 8'(Y_MAX)) begin
                        plats[idx]     <= respawn_y;
                        spawn_acc[idx] <= 1'b1;
                    end else begin
                        plats[idx] <= sum[6:0];
                    end
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) state <= DONE;
                end
                DONE: begin
                    valid_q <= 1'b1;
                    spawn_q <= spawn_acc;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.position_plats = plats;
    assign bus.prev_plats     = prev;
    assign bus.plats_valid    = valid_q;
    assign bus.busy           = busy_q;
    assign bus.spawn          = spawn_q;

endmodule

// File: tb/tb_plat_scroller.sv
// Self-checking bench for plat_scroller (default build, respawn row 0).
`timescale 1ns/1ps
module tb_plat_scroller;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    plat_scroller_if bus();

    plat_scroller #(.Y_MAX(116), .SPEED_SHIFT(3), .MAX_SPEED(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: platform heights as plain integers
    int ref_y[4];
    int ref_prev[4];
    int ref_spawn;

    function automatic logic [27:0] pack_arr(input int a[4]);
        logic [27:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) p[7*k +: 7] = 7'(a[k]);
        return p;
    endfunction

    function automatic int ref_speed(input logic [31:0] s);
        int unsigned lvl;
        lvl = s / 8;
        return (lvl > 3) ? 4 : int'(lvl) + 1;
    endfunction

    task automatic ref_layout();
        ref_y = '{0, 29, 58, 87};
        ref_prev = ref_y;
        ref_spawn = 0;
    endtask

    task automatic ref_sweep(input logic [31:0] s);
        int spd, n;
        spd = ref_speed(s);
        ref_prev = ref_y;
        ref_spawn = 0;
        for (int k = 0; k < 4; k++) begin
            n = ref_y[k] + spd;
            if (n >= 116) begin
                ref_y[k] = 0;
                ref_spawn |= (1 << k);
            end else begin
                ref_y[k] = n;
            end
        end
    endtask

    // Issue one step, optionally a second one sampled at edge t+extra_at,
    // and observe 8 cycles afterwards
    task automatic do_step(input logic [31:0] score, input int extra_at,
                           output int vcycle, output int vcount,
                           output logic [3:0] spw, output logic busy_mid,
                           output logic busy_end);
        vcycle = -1; vcount = 0; spw = '0; busy_mid = 1'b0; busy_end = 1'b1;
        bus.curr_score = score;
        bus.step = 1'b1;
        @(posedge clk); #1;
        bus.step = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            bus.step = (c == extra_at);
            @(posedge clk); #1;
            bus.step = 1'b0;
            if (c == 2) busy_mid = bus.busy;
            if (c == 6) busy_end = bus.busy;
            if (bus.plats_valid) begin
                vcount++;
                if (vcycle < 0) begin
                    vcycle = c;
                    spw = bus.spawn;
                end
            end
        end
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(posedge clk); #1;
        bus.restart = 1'b0;
        ref_layout();
    endtask

    task automatic test_reset();
        int vc, vn; logic [3:0] sp; logic bm, be;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        ref_layout();
        n_cmp++; if (bus.position_plats !== pack_arr(ref_y)) begin n_err++; $display("FAIL reset_pos: got %h want %h", bus.position_plats, pack_arr(ref_y)); end
        // disturb state, then assert reset in the middle of a sweep
        bus.curr_score = 32'd0;
        bus.step = 1'b1;
        @(posedge clk); #1;
        bus.step = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        n_cmp++; if (bus.position_plats !== 28'({7'd87, 7'd58, 7'd29, 7'd0})) begin n_err++; $display("FAIL reset_async_pos: got %h want %h", bus.position_plats, {7'd87, 7'd58, 7'd29, 7'd0}); end
        n_cmp++; if (bus.prev_plats !== pack_arr(ref_prev)) begin n_err++; $display("FAIL reset_prev: got %h want %h", bus.prev_plats, pack_arr(ref_prev)); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.plats_valid !== 1'b0 || bus.spawn !== 4'd0) begin n_err++; $display("FAIL reset_valid_spawn: got %b/%b want 0/0", bus.plats_valid, bus.spawn); end
        @(posedge clk); @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        ref_layout();
        // no leftover sweep may complete after reset
        do_step(32'd0, 0, vc, vn, sp, bm, be);
        ref_sweep(32'd0);
        n_cmp++; if (vn !== 1) begin n_err++; $display("FAIL reset_clean_sweep: got %0d pulses want 1", vn); end
        pulse_restart();
    endtask

    task automatic test_single_step();
        int vc, vn; logic [3:0] sp; logic bm, be;
        do_step(32'd0, 0, vc, vn, sp, bm, be);
        ref_sweep(32'd0);
        n_cmp++; if (bus.position_plats !== 28'({7'd88, 7'd59, 7'd30, 7'd1})) begin n_err++; $display("FAIL single_pos: got %h want %h", bus.position_plats, {7'd88, 7'd59, 7'd30, 7'd1}); end
        n_cmp++; if (bus.prev_plats !== pack_arr(ref_prev)) begin n_err++; $display("FAIL single_prev: got %h want %h", bus.prev_plats, pack_arr(ref_prev)); end
        n_cmp++; if (vc !== 5 || vn !== 1) begin n_err++; $display("FAIL single_latency: got cycle %0d count %0d want 5/1", vc, vn); end
        n_cmp++; if (sp !== 4'd0) begin n_err++; $display("FAIL single_spawn: got %b want 0000", sp); end
        n_cmp++; if (bm !== 1'b1 || be !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b/%b want 1/0", bm, be); end
    endtask

    task automatic test_speed();
        logic [31:0] scores[3];
        int vc, vn; logic [3:0] sp; logic bm, be;
        scores = '{32'd24, 32'd1000, 32'd7};
        foreach (scores[i]) begin
            do_step(scores[i], 0, vc, vn, sp, bm, be);
            ref_sweep(scores[i]);
            n_cmp++; if (bus.position_plats !== pack_arr(ref_y) || vc !== 5) begin n_err++; $display("FAIL speed_score%0d: got %h (cycle %0d) want %h", scores[i], bus.position_plats, vc, pack_arr(ref_y)); end
        end
    endtask

    task automatic test_respawn();
        int vc, vn; logic [3:0] sp; logic bm, be;
        // speed 4: y3 climbs 87 -> 111 -> 115 (no spawn) -> respawn
        pulse_restart();
        for (int i = 0; i < 8; i++) begin
            do_step(32'd40, 0, vc, vn, sp, bm, be);
            ref_sweep(32'd40);
            n_cmp++; if (bus.position_plats !== pack_arr(ref_y) || sp !== 4'(ref_spawn)) begin n_err++; $display("FAIL respawn_fast_%0d: got %h/%b want %h/%b", i, bus.position_plats, sp, pack_arr(ref_y), 4'(ref_spawn)); end
            if (i == 6) begin
                n_cmp++; if (bus.position_plats[27:21] !== 7'd115 || sp !== 4'd0) begin n_err++; $display("FAIL respawn_edge_115: got y3 %0d spawn %b want 115/0000", bus.position_plats[27:21], sp); end
            end
        end
        n_cmp++; if (bus.position_plats[27:21] !== 7'd0 || sp !== 4'b1000) begin n_err++; $display("FAIL respawn_fast_final: got y3 %0d spawn %b want 0/1000", bus.position_plats[27:21], sp); end
        // speed 1: 28 steps bring y3 to 115, the 29th respawns it
        pulse_restart();
        for (int i = 0; i < 29; i++) begin
            do_step(32'd0, 0, vc, vn, sp, bm, be);
            ref_sweep(32'd0);
            n_cmp++; if (bus.position_plats !== pack_arr(ref_y) || sp !== 4'(ref_spawn)) begin n_err++; $display("FAIL respawn_slow_%0d: got %h/%b want %h/%b", i, bus.position_plats, sp, pack_arr(ref_y), 4'(ref_spawn)); end
        end
        n_cmp++; if (bus.position_plats[27:21] !== 7'd0 || sp !== 4'b1000) begin n_err++; $display("FAIL respawn_slow_final: got y3 %0d spawn %b want 0/1000", bus.position_plats[27:21], sp); end
    endtask

    task automatic test_dropped_step();
        int vc, vn; logic [3:0] sp; logic bm, be;
        int at[2];
        at = '{2, 5};
        foreach (at[i]) begin
            do_step(32'd8, at[i], vc, vn, sp, bm, be);
            ref_sweep(32'd8);
            n_cmp++; if (vn !== 1 || vc !== 5) begin n_err++; $display("FAIL dropped_at%0d_pulses: got %0d (cycle %0d) want 1 (5)", at[i], vn, vc); end
            n_cmp++; if (bus.position_plats !== pack_arr(ref_y)) begin n_err++; $display("FAIL dropped_at%0d_pos: got %h want %h", at[i], bus.position_plats, pack_arr(ref_y)); end
        end
    endtask

    task automatic test_restart();
        int vn, vc; logic [3:0] sp; logic bm, be;
        // restart sampled at edge t+2 of a sweep
        bus.curr_score = 32'd16;
        bus.step = 1'b1;
        @(posedge clk); #1;
        bus.step = 1'b0;
        @(posedge clk); #1;
        bus.restart = 1'b1;
        @(posedge clk); #1;
        bus.restart = 1'b0;
        ref_layout();
        n_cmp++; if (bus.position_plats !== pack_arr(ref_y) || bus.prev_plats !== pack_arr(ref_y)) begin n_err++; $display("FAIL restart_mid_layout: got %h/%h want %h", bus.position_plats, bus.prev_plats, pack_arr(ref_y)); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL restart_mid_busy: got %b want 0", bus.busy); end
        vn = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.plats_valid) vn++;
        end
        n_cmp++; if (vn !== 0) begin n_err++; $display("FAIL restart_mid_novalid: got %0d pulses want 0", vn); end
        // step and restart on the same edge: restart wins
        do_step(32'd0, 0, vc, vn, sp, bm, be);
        ref_sweep(32'd0);
        bus.step = 1'b1; bus.restart = 1'b1;
        @(posedge clk); #1;
        bus.step = 1'b0; bus.restart = 1'b0;
        ref_layout();
        n_cmp++; if (bus.busy !== 1'b0 || bus.position_plats !== pack_arr(ref_y)) begin n_err++; $display("FAIL restart_with_step: got busy %b pos %h want 0/%h", bus.busy, bus.position_plats, pack_arr(ref_y)); end
        vn = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.plats_valid) vn++;
        end
        n_cmp++; if (vn !== 0) begin n_err++; $display("FAIL restart_with_step_novalid: got %0d pulses want 0", vn); end
    endtask

    task automatic test_gameover();
        int vc, vn; logic [3:0] sp; logic bm, be;
        bus.gameover = 1'b1;
        do_step(32'd0, 3, vc, vn, sp, bm, be);
        n_cmp++; if (vn !== 0 || bm !== 1'b0 || bus.position_plats !== pack_arr(ref_y)) begin n_err++; $display("FAIL gameover_block: got pulses %0d busy %b pos %h want 0/0/%h", vn, bm, bus.position_plats, pack_arr(ref_y)); end
        // gameover rising mid-sweep does not abort it
        bus.gameover = 1'b0;
        bus.curr_score = 32'd20;
        bus.step = 1'b1;
        @(posedge clk); #1;
        bus.step = 1'b0;
        bus.gameover = 1'b1;
        vc = -1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (bus.plats_valid && vc < 0) vc = c;
        end
        ref_sweep(32'd20);
        n_cmp++; if (vc !== 5 || bus.position_plats !== pack_arr(ref_y)) begin n_err++; $display("FAIL gameover_mid_sweep: got cycle %0d pos %h want 5/%h", vc, bus.position_plats, pack_arr(ref_y)); end
        bus.gameover = 1'b0;
    endtask

    task automatic test_random();
        int vc, vn, xa; logic [3:0] sp; logic bm, be;
        logic [31:0] s;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) pulse_restart();
            s = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            xa = $urandom_range(0, 5);
            do_step(s, xa, vc, vn, sp, bm, be);
            ref_sweep(s);
            n_cmp++; if (bus.position_plats !== pack_arr(ref_y) || bus.prev_plats !== pack_arr(ref_prev)) begin n_err++; $display("FAIL random_%0d_pos: got %h/%h want %h/%h", i, bus.position_plats, bus.prev_plats, pack_arr(ref_y), pack_arr(ref_prev)); end
            n_cmp++; if (sp !== 4'(ref_spawn) || vc !== 5 || vn !== 1) begin n_err++; $display("FAIL random_%0d_pulse: got spawn %b cycle %0d count %0d want %b/5/1", i, sp, vc, vn, 4'(ref_spawn)); end
        end
    endtask

    initial begin
        bus.step = 1'b0;
        bus.restart = 1'b0;
        bus.gameover = 1'b0;
        bus.curr_score = 32'd0;
        test_reset();
        test_single_step();
        test_speed();
        test_respawn();
        test_dropped_step();
        test_restart();
        test_gameover();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
